// File: rtl/tone_detector.sv
// Square-wave period meter: measures rising-to-rising intervals of tone_in and
// tracks tone presence and lock onto a target pitch.
module tone_detector #(
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned TARGET_PERIOD = 65536,
  parameter int unsigned TOL           = 512,
  parameter int unsigned MIN_PERIOD    = 64,
  parameter int unsigned TIMEOUT       = 200000,
  parameter int unsigned LOCK_COUNT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             tone_present,
  output logic             tone_match,
  output logic             timeout
);

  localparam int unsigned MC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]        MIN_C     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]        TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic signed [CNT_W:0]   TARGET_C  = (CNT_W+1)'(TARGET_PERIOD);
  localparam logic [CNT_W:0]          TOL_C     = (CNT_W+1)'(TOL);
  localparam logic [MC_W-1:0]         LOCK_C    = MC_W'(LOCK_COUNT);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             tone_present_q, tone_present_d;
  logic             tone_match_q, tone_match_d;
  logic             timeout_q, timeout_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;

  logic                rise;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]      abs_diff;
  logic                in_tol;

  // sync_q[1] is the synchronized input, sync_q[2] its delayed copy.
  assign sync_d = {sync_q[1:0], tone_in};
  assign rise   = sync_q[1] & ~sync_q[2];

  always_comb begin
    diff     = $signed({1'b0, cnt_q}) - TARGET_C;
    abs_diff = diff[CNT_W] ? unsigned'(-diff) : unsigned'(diff);
    in_tol   = (abs_diff <= TOL_C);
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    tone_present_d = tone_present_q;
    tone_match_d   = tone_match_q;
    timeout_d      = 1'b0;
    match_cnt_d    = match_cnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          cnt_d   = CNT_W'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // An accepted edge takes priority over expiry, so cnt never passes TIMEOUT.
        if (rise && (cnt_q >= MIN_C)) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          cnt_d          = CNT_W'(1);
          tone_present_d = 1'b1;
          if (in_tol) begin
            if (match_cnt_q != LOCK_C) begin
              match_cnt_d = match_cnt_q + MC_W'(1);
            end
            tone_match_d = (match_cnt_d == LOCK_C);
          end else begin
            match_cnt_d  = '0;
            tone_match_d = 1'b0;
          end
        end else if (cnt_q == TIMEOUT_C) begin
          state_d        = IDLE;
          timeout_d      = 1'b1;
          tone_present_d = 1'b0;
          tone_match_d   = 1'b0;
          match_cnt_d    = '0;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sync_q         <= '0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      tone_present_q <= 1'b0;
      tone_match_q   <= 1'b0;
      timeout_q      <= 1'b0;
      match_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      tone_present_q <= tone_present_d;
      tone_match_q   <= tone_match_d;
      timeout_q      <= timeout_d;
      match_cnt_q    <= match_cnt_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign tone_present = tone_present_q;
  assign tone_match   = tone_match_q;
  assign timeout      = timeout_q;

endmodule
